// File: rtl/medidor_periodo.sv
// medidor_periodo: measures period and high time of a slow asynchronous input in C_50Mhz cycles.
// Defining MEDIDOR_FILTRO_EN inserts a 3-cycle glitch filter ahead of the edge detector.
module medidor_periodo #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic             C_50Mhz,
  input  logic             Reset,
  input  logic             S_in,
  output logic [CNT_W-1:0] periodo,
  output logic [CNT_W-1:0] alto,
  output logic             valido,
  output logic             timeout
);

  // state  | meaning
  // ESPERA | idle after reset or timeout; the next rising edge starts a measurement
  // MEDIR  | counting cycles since the last rising edge
  typedef enum logic {ESPERA = 1'b0, MEDIR = 1'b1} estado_t;

  localparam longint unsigned CNT_MAX = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                      : ((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

  // The counter must reach TIMEOUT-1 without wrapping.
  if (TIMEOUT < 1 || 64'(TIMEOUT) > CNT_MAX) begin : g_param_check
    $error("medidor_periodo: TIMEOUT must lie in 1 .. 2**CNT_W-1");
  end

  logic r_sync1, r_sync2, r_prev;
  logic w_nivel, w_sube, w_baja;

  always_ff @(posedge C_50Mhz) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= S_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MEDIDOR_FILTRO_EN
  logic       r_filt;
  logic [1:0] r_fcnt;

  // Level follows the synchronized input only after it differs for 3 cycles in a row.
  always_ff @(posedge C_50Mhz) begin
    if (Reset) begin
      r_filt <= 1'b0;
      r_fcnt <= 2'd0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= 2'd0;
    end else if (r_fcnt == 2'd2) begin
      r_filt <= r_sync2;
      r_fcnt <= 2'd0;
    end else begin
      r_fcnt <= r_fcnt + 2'd1;
    end
  end

  assign w_nivel = r_filt;
`else
  assign w_nivel = r_sync2;
`endif

  always_ff @(posedge C_50Mhz) begin
    if (Reset) r_prev <= 1'b0;
    else       r_prev <= w_nivel;
  end

  assign w_sube = w_nivel & ~r_prev;
  assign w_baja = ~w_nivel & r_prev;

  estado_t          r_estado;
  logic [CNT_W-1:0] r_cnt, r_alto_tmp, r_periodo, r_alto;
  logic             r_vio_baja, r_valido, r_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge C_50Mhz) begin
    if (Reset) begin
      r_estado   <= ESPERA;
      r_cnt      <= '0;
      r_alto_tmp <= '0;
      r_vio_baja <= 1'b0;
      r_periodo  <= '0;
      r_alto     <= '0;
      r_valido   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      case (r_estado)
        ESPERA: begin
          if (w_sube) begin
            r_cnt      <= '0;
            r_vio_baja <= 1'b0;
            r_estado   <= MEDIR;
          end
        end
        MEDIR: begin
          // A rising edge on the terminal-count cycle still closes a valid measurement.
          if (w_sube) begin
            r_periodo  <= w_cnt_inc;
            r_alto     <= r_vio_baja ? r_alto_tmp : w_cnt_inc;
            r_valido   <= 1'b1;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_vio_baja <= 1'b0;
          end else if (r_cnt == TC) begin
            r_timeout <= 1'b1;
            r_estado  <= ESPERA;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_baja && !r_vio_baja) begin
              r_alto_tmp <= w_cnt_inc;
              r_vio_baja <= 1'b1;
            end
          end
        end
        default: r_estado <= ESPERA;
      endcase
    end
  end

  assign periodo = r_periodo;
  assign alto    = r_alto;
  assign valido  = r_valido;
  assign timeout = r_timeout;

endmodule

// File: doc/medidor_periodo.md
# medidor_periodo

Period and high-time meter for a slow, asynchronous digital input, timed against the 50 MHz system clock. It is the receiving end of the divided-clock path: it takes a low-rate square wave, such as the 1 Hz LED/tick signal or an external pulse source, and reports its period and high time as 50 MHz cycle counts. Each completed cycle produces a one-clock `valido` strobe. It sits beside the frequency divider and feeds the display and checking logic of the lab board.

## Interface
- `CNT_W`, default 32: width of the period and high-time counts.
- `TIMEOUT`, default 100_000_000: cycles without a rising edge before the input is declared dead (2 s at 50 MHz).

Ports:
- `C_50Mhz`  in  1  system clock; all logic runs on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `S_in`  in  1  measured signal; asynchronous to `C_50Mhz`.
- `periodo`  out  `CNT_W`  last measured period, in cycles.
- `alto`  out  `CNT_W`  last measured high time, in cycles.
- `valido`  out  1  one-cycle strobe when `periodo`/`alto` update.
- `timeout`  out  1  sticky flag: no rising edge seen within `TIMEOUT` cycles.

## Operation
- **Input path:** `S_in` passes through a 2-flop synchronizer, then an edge-detect register. This yields one-cycle `sube` (rise) and `baja` (fall) events.
- **FSM states:** `ESPERA` and `MEDIR`.
- **`ESPERA`:**
  - `baja` is ignored.
  - On `sube`: `cnt` ← 0, `vio_baja` ← 0, go to `MEDIR`.
- **`MEDIR`:** `cnt` increments every cycle.
  - On the first `baja`: latch `alto_tmp` ← `cnt`+1, set `vio_baja`.
  - On `sube`:
    - `periodo` ← `cnt`+1.
    - `alto` ← `alto_tmp` if `vio_baja`, else ← `cnt`+1.
    - `valido` ← 1 for one cycle; `timeout` ← 0.
    - `cnt` ← 0, `vio_baja` ← 0; stay in `MEDIR`.
  - If `cnt` == `TIMEOUT`−1 with no `sube` that cycle: `timeout` ← 1, go to `ESPERA`. `periodo` and `alto` keep their last values.
- **Simultaneous events:**
  - `sube` and timeout in the same cycle: `sube` wins, the measurement is valid, no timeout.
  - `sube` and `baja` cannot coincide, since both come from the same edge register.
- **Arithmetic:** `cnt` is `CNT_W` bits. `TIMEOUT` ≤ 2^`CNT_W`−1 guarantees no wrap. Parameters violating this are a compile-time error via an elaboration check.
- **Reset:** may arrive mid-measurement.
  - FSM → `ESPERA`; `cnt`, `alto_tmp`, `vio_baja` and the synchronizer/edge flops are cleared.
  - Output reset values: `periodo`=0, `alto`=0, `valido`=0, `timeout`=0.
  - The first `sube` after reset only starts a measurement, so the first `valido` requires two rising edges.

## Timing
- **Edge latency:** an `S_in` transition sampled at clock edge k produces `sube`/`baja` in cycle k+2 (no filter).
- **Output update:** `periodo`, `alto` and `valido` are registered and change on the clock edge after the `sube` cycle.
- **Measured values:** equal the input period/high time rounded to the 50 MHz grid. Synchronizer latency cancels because both edges see the same delay.
- **Input rate:**
  - Minimum measurable period is 4 cycles; minimum high or low phase is 2 cycles.
  - Shorter phases give undefined counts but never lock up the FSM.
- **`timeout` timing:**
  - Asserts exactly `TIMEOUT` cycles after the last `sube` if no new `sube` arrives.
  - Clears in the same cycle `valido` pulses.

## Configuration
- **Macro:** `MEDIDOR_FILTRO_EN`.
- **Defined:** a glitch filter sits between the synchronizer and the edge detector. The filtered level changes only after the synchronized input holds the new value for 3 consecutive cycles.
  - Edge latency becomes k+5.
  - The minimum high/low phase becomes 4 cycles.
  - Pulses of 1–2 cycles are suppressed: no `sube`/`baja`, and counts are unaffected.
- **Not defined:** the filter is absent and there is no extra latency. Every synchronized transition produces an event.

## Test plan
- Reset asserted mid-`MEDIR`, then released; `S_in` toggling → next clock: `periodo`=0, `alto`=0, `valido`=0, `timeout`=0. First `valido` appears only after the second rising edge.
- `S_in` period 10 cycles, high 4, 5 periods → four `valido` pulses, each with `periodo`=10 and `alto`=4, spaced exactly 10 cycles apart.
- `TIMEOUT`=50; one rising edge, then `S_in` held low → `timeout`=1 exactly 50 cycles after `sube`, no `valido`. After two new edges 8 apart: `valido` with `periodo`=8 and `timeout`=0 in the same cycle.
- Input period changes from 10 to 16 (high 8) mid-run → the first `valido` after the change reports 16/8, with no stale mix of values.
- Rising edge lands exactly at `cnt`=`TIMEOUT`−1 → `valido` with `periodo`=`TIMEOUT`; `timeout` stays 0.
- With `MEDIDOR_FILTRO_EN`: a 2-cycle low glitch inside a 20-cycle high phase of a 40-cycle period → `periodo`=40, `alto`=20. Without the macro: `alto` reports the cycles up to the glitch.
